// File: rtl/hdlc_chk_pkg.sv
// Shared constants and helpers for the HDLC receive-path protocol checker.
package hdlc_chk_pkg;

    localparam logic [7:0] FLAG_PATTERN = 8'h7E;

    localparam int unsigned CHK_FLAG  = 0;
    localparam int unsigned CHK_SPUR  = 1;
    localparam int unsigned CHK_ABORT = 2;
    localparam int unsigned CHK_EOF   = 3;
    localparam int unsigned NUM_CHK   = 4;

    // Saturating add: results above max clamp to max instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max}) begin
            return max;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/hdlc_chk_chan.sv
// Per-channel check logic: flag shift register, expectation pipelines and
// combinational failure flags for the current edge.
module hdlc_chk_chan
    import hdlc_chk_pkg::*;
#(
    parameter int unsigned FLAG_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    input  logic               flag_detect,
    input  logic               valid_frame,
    input  logic               abort_detect,
    input  logic               abort_signal,
    input  logic               eof,
    output logic [NUM_CHK-1:0] fail
);

    logic [7:0]              shift_q;
    logic [FLAG_LATENCY-1:0] expect_q;
    logic                    abort_pend_q;
    logic                    vf_q;
    logic                    eof_pend_q;
    logic                    flag_hit;
    logic                    flag_due;

    // Pattern completes at this edge when the incoming bit closes the 8-sample window.
    assign flag_hit = ({shift_q[6:0], rx} == FLAG_PATTERN);
    assign flag_due = expect_q[FLAG_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= 8'hFF;
            expect_q     <= '0;
            abort_pend_q <= 1'b0;
            vf_q         <= 1'b0;
            eof_pend_q   <= 1'b0;
        end else begin
            shift_q      <= {shift_q[6:0], rx};
            expect_q     <= (expect_q << 1) | FLAG_LATENCY'(flag_hit);
            abort_pend_q <= abort_detect & valid_frame;
            vf_q         <= valid_frame;
            eof_pend_q   <= vf_q & ~valid_frame;
        end
    end

    assign fail[CHK_FLAG]  = flag_due & ~flag_detect;
    assign fail[CHK_SPUR]  = flag_detect & ~flag_due;
    assign fail[CHK_ABORT] = abort_pend_q & ~abort_signal;
    assign fail[CHK_EOF]   = eof_pend_q & ~eof;

endmodule

// File: rtl/hdlc_rx_protocol_checker.sv
// Passive multi-channel HDLC Rx protocol checker with saturating error
// counters and sticky debug status.
module hdlc_rx_protocol_checker
    import hdlc_chk_pkg::*;
#(
    parameter int unsigned CHANNELS     = 1,
    parameter int unsigned FLAG_LATENCY = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Clr,
    input  logic                En,
    input  logic [CHANNELS-1:0] Rx,
    input  logic [CHANNELS-1:0] Rx_FlagDetect,
    input  logic [CHANNELS-1:0] Rx_ValidFrame,
    input  logic [CHANNELS-1:0] Rx_AbortDetect,
    input  logic [CHANNELS-1:0] Rx_AbortSignal,
    input  logic [CHANNELS-1:0] Rx_EoF,
    output logic [CNT_W-1:0]    ErrCnt_Flag,
    output logic [CNT_W-1:0]    ErrCnt_Spur,
    output logic [CNT_W-1:0]    ErrCnt_Abort,
    output logic [CNT_W-1:0]    ErrCnt_EoF,
    output logic [CNT_W-1:0]    ErrCnt_Total,
    output logic [CHANNELS-1:0] ErrChan,
    output logic [3:0]          ErrKind,
    output logic                ErrPulse
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [NUM_CHK-1:0]  chan_fail [CHANNELS];
    logic [CHANNELS-1:0] chan_any;
    logic [7:0]          inc [NUM_CHK];
    logic [7:0]          inc_total;
    logic [NUM_CHK-1:0]  kind_any;
    logic [CNT_W-1:0]    cnt_q [NUM_CHK];
    logic [CNT_W-1:0]    cnt_d [NUM_CHK];
    logic [CNT_W-1:0]    total_q;
    logic [CNT_W-1:0]    total_d;
    logic [CHANNELS-1:0] err_chan_q;
    logic [NUM_CHK-1:0]  err_kind_q;
    logic                pulse_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        hdlc_chk_chan #(
            .FLAG_LATENCY(FLAG_LATENCY)
        ) u_chan (
            .clk         (Clk),
            .rst_n       (Rst),
            .rx          (Rx[c]),
            .flag_detect (Rx_FlagDetect[c]),
            .valid_frame (Rx_ValidFrame[c]),
            .abort_detect(Rx_AbortDetect[c]),
            .abort_signal(Rx_AbortSignal[c]),
            .eof         (Rx_EoF[c]),
            .fail        (chan_fail[c])
        );
        assign chan_any[c] = |chan_fail[c];
    end

    // Popcount of failing channels per check, then saturating next-state values.
    always_comb begin
        inc_total = '0;
        kind_any  = '0;
        for (int k = 0; k < NUM_CHK; k++) begin
            inc[k] = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                inc[k] = inc[k] + 8'(chan_fail[c][k]);
            end
            inc_total   = inc_total + inc[k];
            kind_any[k] = (inc[k] != '0);
            cnt_d[k]    = CNT_W'(sat_add(32'(cnt_q[k]), 32'(inc[k]), CNT_MAX));
        end
        total_d = CNT_W'(sat_add(32'(total_q), 32'(inc_total), CNT_MAX));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int k = 0; k < NUM_CHK; k++) begin
                cnt_q[k] <= '0;
            end
            total_q    <= '0;
            err_chan_q <= '0;
            err_kind_q <= '0;
            pulse_q    <= 1'b0;
        end else if (Clr) begin
            for (int k = 0; k < NUM_CHK; k++) begin
                cnt_q[k] <= '0;
            end
            total_q    <= '0;
            err_chan_q <= '0;
            err_kind_q <= '0;
            pulse_q    <= 1'b0;
        end else if (En) begin
            for (int k = 0; k < NUM_CHK; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            total_q    <= total_d;
            err_chan_q <= err_chan_q | chan_any;
            err_kind_q <= err_kind_q | kind_any;
            pulse_q    <= |chan_any;
        end else begin
            pulse_q <= 1'b0;
        end
    end

    assign ErrCnt_Flag  = cnt_q[CHK_FLAG];
    assign ErrCnt_Spur  = cnt_q[CHK_SPUR];
    assign ErrCnt_Abort = cnt_q[CHK_ABORT];
    assign ErrCnt_EoF   = cnt_q[CHK_EOF];
    assign ErrCnt_Total = total_q;
    assign ErrChan      = err_chan_q;
    assign ErrKind      = err_kind_q;
    assign ErrPulse     = pulse_q;

endmodule
